// File: rtl/controle_io.sv
// controle_io: handshake controller for the IN/OUT/HALT instructions.
// It debounces the confirm pushbutton, and each debounced press releases exactly
// one stalled I/O instruction.
//
// Ports:
//   clock, reset  : system clock and synchronous active-high reset
//   stop, in, out : stall, IN-pending and OUT-pending requests from the control unit
//   botao         : raw asynchronous confirm pushbutton (active-high)
//   chaves        : raw switch value, zero-extended into entrada on IN
//   dado_reg      : register value shown on OUT, latched into saida
//   sinal         : one-cycle completion pulse back to the control unit
//   entrada       : switch sample captured for IN
//   saida         : last value written by OUT
//   aguardando    : waiting for a user press
//   parado        : processor halted; only reset clears it
module controle_io #(
  parameter int LARGURA_CHAVES  = 16,
  parameter int DEBOUNCE_CICLOS = 500000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stop,
  input  logic                      in,
  input  logic                      out,
  input  logic                      botao,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  input  logic [31:0]               dado_reg,
  output logic                      sinal,
  output logic [31:0]               entrada,
  output logic [31:0]               saida,
  output logic                      aguardando,
  output logic                      parado
);

  localparam int         CW      = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {OCIOSO, ESPERA, PULSO, SOLTA} estado_t;

  estado_t                   estado, estado_prox;
  logic                      botao_s1, botao_s2;
  logic [LARGURA_CHAVES-1:0] chaves_s1, chaves_s2;
  logic [CW-1:0]             cnt;
  logic                      deb, deb_q;
  logic                      press;
  logic                      op_in;

  // Synchronizers and debounce. The counter only advances while the synchronized
  // level disagrees with the accepted level. Any agreement restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      botao_s1  <= 1'b0;
      botao_s2  <= 1'b0;
      chaves_s1 <= '0;
      chaves_s2 <= '0;
      cnt       <= '0;
      deb       <= 1'b0;
      deb_q     <= 1'b0;
    end else begin
      botao_s1  <= botao;
      botao_s2  <= botao_s1;
      chaves_s1 <= chaves;
      chaves_s2 <= chaves_s1;
      deb_q     <= deb;
      if (botao_s2 != deb) begin
        if (cnt == CNT_MAX) begin
          deb <= ~deb;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // A button that is already held when ESPERA is entered produces no edge here.
  // The user must therefore release the button and press it again.
  assign press = deb & ~deb_q;

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO: if (!parado && stop && (in || out)) estado_prox = ESPERA;
      ESPERA: begin
        if (!stop)      estado_prox = OCIOSO;
        else if (press) estado_prox = PULSO;
      end
      PULSO:  estado_prox = SOLTA;
      // Hold here until the button is released, so a long press completes only once.
      SOLTA:  if (!deb) estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      op_in   <= 1'b0;
      entrada <= '0;
      saida   <= '0;
      parado  <= 1'b0;
    end else begin
      estado <= estado_prox;
      // When both in and out are high, in has priority.
      if (estado == OCIOSO && estado_prox == ESPERA) op_in <= in;
      if (estado == ESPERA && estado_prox == PULSO && op_in) entrada <= 32'(chaves_s2);
      if (estado == PULSO && !op_in) saida <= dado_reg;
      // A halt is sticky. It also blocks OCIOSO from starting new I/O until reset.
      if (estado == OCIOSO && stop && !in && !out) parado <= 1'b1;
    end
  end

  assign sinal      = (estado == PULSO);
  assign aguardando = (estado == ESPERA);

endmodule
